// File: rtl/cpu_types_pkg.sv
// Shared CPU types: ALU operation/word types plus the ALU arbiter state and request/response bundles.
package cpu_types_pkg;

   localparam int WORD_W        = 32;
   localparam int ALU_ARB_PORTS = 2;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4,
      ALU_SLL = 3'd5,
      ALU_SRL = 3'd6,
      ALU_SRA = 3'd7
   } aluop_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   typedef struct packed {
      aluop_t op;
      word_t  a;
      word_t  b;
   } alu_req_t;

   function automatic logic [ALU_ARB_PORTS-1:0] port_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/alu_arbiter_rr_pick2.sv
// Combinational two-way picker: round-robin when ALU_ARB_RR_EN is defined, otherwise fixed priority to port 0.
module rr_pick2
   import cpu_types_pkg::*;
(
   input  logic [ALU_ARB_PORTS-1:0] valid,
   input  logic                     last_grant,
   output logic                     grant_valid,
   output logic                     grant_idx
);

   assign grant_valid = |valid;

`ifdef ALU_ARB_RR_EN
   // On contention the port opposite the previous winner goes next.
   always_comb begin
      grant_idx = valid[1];
      if (valid == 2'b11) begin
         grant_idx = ~last_grant;
      end
   end
`else
   logic unused_last_grant;
   assign unused_last_grant = last_grant;
   assign grant_idx         = valid[1] & ~valid[0];
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between the execute stage (port 0) and the branch/AGU (port 1).
// ALU_ARB_RR_EN selects round-robin contention handling; without it port 0 has fixed priority.
//
// state | meaning
// IDLE  | no operation outstanding, accept any valid request
// EXEC  | latched operands drive the ALU, result captured at the next edge
// RESP  | response held for the owner; handshake may accept the next request
module alu_arbiter
   import cpu_types_pkg::*;
#(
   parameter bit RESET_LAST_GRANT = 1'b1
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [ALU_ARB_PORTS-1:0] req_valid,
   output logic [ALU_ARB_PORTS-1:0] req_ready,
   input  aluop_t                   req_op0,
   input  aluop_t                   req_op1,
   input  word_t                    req_a0,
   input  word_t                    req_b0,
   input  word_t                    req_a1,
   input  word_t                    req_b1,
   output logic [ALU_ARB_PORTS-1:0] rsp_valid,
   input  logic [ALU_ARB_PORTS-1:0] rsp_ready,
   output word_t                    rsp_result,
   output logic                     rsp_zero,
   output logic                     rsp_neg,
   output logic                     rsp_ovf,
   output aluop_t                   alu_op,
   output word_t                    alu_pa,
   output word_t                    alu_pb,
   input  word_t                    alu_presult,
   input  logic                     alu_zero,
   input  logic                     alu_neg,
   input  logic                     alu_ovf
);

   arb_state_t state;
   logic       owner;
   logic       last_grant;
   logic       grant_valid;
   logic       grant_idx;
   logic       rsp_hs;
   logic       accept_ok;
   alu_req_t   req_sel;

   rr_pick2 u_pick (
      .valid       (req_valid),
      .last_grant  (last_grant),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   assign rsp_hs    = (state == RESP) && rsp_ready[owner];
   // Gated by RST so req_ready reads as 0 while reset is held, regardless of req_valid.
   assign accept_ok = !RST && grant_valid && ((state == IDLE) || rsp_hs);
   assign req_ready = accept_ok ? port_onehot(grant_idx) : '0;

   always_comb begin
      req_sel.op = req_op0;
      req_sel.a  = req_a0;
      req_sel.b  = req_b0;
      if (grant_idx) begin
         req_sel.op = req_op1;
         req_sel.a  = req_a1;
         req_sel.b  = req_b1;
      end
   end

`ifdef ALU_ARB_RR_EN
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         last_grant <= RESET_LAST_GRANT;
      end else if (accept_ok) begin
         last_grant <= grant_idx;
      end
   end
`else
   assign last_grant = RESET_LAST_GRANT;
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= IDLE;
         owner      <= 1'b0;
         alu_op     <= ALU_ADD;
         alu_pa     <= '0;
         alu_pb     <= '0;
         rsp_valid  <= '0;
         rsp_result <= '0;
         rsp_zero   <= 1'b0;
         rsp_neg    <= 1'b0;
         rsp_ovf    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept_ok) begin
                  alu_op <= req_sel.op;
                  alu_pa <= req_sel.a;
                  alu_pb <= req_sel.b;
                  owner  <= grant_idx;
                  state  <= EXEC;
               end
            end
            EXEC: begin
               rsp_result <= alu_presult;
               rsp_zero   <= alu_zero;
               rsp_neg    <= alu_neg;
               rsp_ovf    <= alu_ovf;
               rsp_valid  <= port_onehot(owner);
               state      <= RESP;
            end
            RESP: begin
               if (rsp_hs) begin
                  rsp_valid <= '0;
                  // Back-to-back: the handshake cycle doubles as the next accept cycle.
                  if (accept_ok) begin
                     alu_op <= req_sel.op;
                     alu_pa <= req_sel.a;
                     alu_pb <= req_sel.b;
                     owner  <= grant_idx;
                     state  <= EXEC;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational ALU (`alu_if`) between two requesters: port 0 is the pipeline execute stage and port 1 is the branch/address-generation unit. Each port uses a valid/ready request channel and a valid/ready response channel. The block selects one request, latches its operands, and drives the ALU from registers. It then captures presult/zero/neg/ovf and holds the response until the owner accepts it. Only one operation is outstanding at a time.

## Interface
- `RESET_LAST_GRANT`, default 1: reset value of the last-grant pointer. A value of 1 means port 0 wins the first contention.
- `CLK` in, 1: clock, rising-edge.
- `RST` in, 1: asynchronous, active-high reset.
- `req_valid` in, [1:0]: request valid, one bit per port.
- `req_ready` out, [1:0]: request accepted this cycle, one bit per port.
- `req_op0`, `req_op1` in, aluop_t: operation for each port.
- `req_a0`, `req_b0`, `req_a1`, `req_b1` in, word_t: operands.
- `rsp_valid` out, [1:0]: response valid; at most one bit is set.
- `rsp_ready` in, [1:0]: response accepted.
- `rsp_result` out, word_t: registered presult (shared by both ports).
- `rsp_zero`, `rsp_neg`, `rsp_ovf` out, 1 each: registered ALU flags.
- `alu_op` out, aluop_t: drives `aluif.alu_op`.
- `alu_pa`, `alu_pb` out, word_t: drive `aluif.pa` and `aluif.pb`.
- `alu_presult` in, word_t: from the ALU.
- `alu_zero`, `alu_neg`, `alu_ovf` in, 1 each: from the ALU.

## Operation
- State machine `arb_state_t`, with states IDLE, EXEC and RESP.
- IDLE:
  - If any `req_valid` is set, grant one port.
  - Pulse `req_ready[g]`.
  - Latch op, a and b into the operand registers; store the owner as `g`.
  - Go to EXEC.
- EXEC:
  - The ALU sees the latched operands.
  - Capture `alu_presult`, `alu_zero`, `alu_neg` and `alu_ovf` into the response registers.
  - Go to RESP.
- RESP:
  - `rsp_valid[owner]` = 1.
  - On `rsp_ready[owner]` with no pending request, go to IDLE.
  - On `rsp_ready[owner]` with a pending request, grant it in the same cycle (same as IDLE) and go to EXEC. This is the back-to-back path.
- Grant selection:
  - Only one valid port: that port wins.
  - Both valid: the port opposite `last_grant` wins.
  - `last_grant` updates on every grant.
- `req_ready` is combinational from the state, `req_valid`, `rsp_ready` and `last_grant`. It is never asserted to more than one port.
- Requesters hold the payload stable while `req_valid && !req_ready`. The arbiter ignores payload changes outside the accept cycle.
- `rsp_ready` on the non-owner port, or outside RESP, is ignored.
- `rsp_ovf` is passed through as the ALU reports it; non-ADD/SUB ops therefore give 0.
- Reset (asynchronous, any state):
  - State goes to IDLE and `last_grant` to `RESET_LAST_GRANT`.
  - Operand registers are cleared and `alu_op` = ALU_ADD.
  - Response registers are cleared and `rsp_valid` = 0.
  - An in-flight operation is dropped with no response.

## Timing
- Reset values of outputs: `req_ready`=0, `rsp_valid`=0, `rsp_result`=0, `rsp_zero`=0, `rsp_neg`=0, `rsp_ovf`=0, `alu_pa`=0, `alu_pb`=0.
- Latency: a request accepted at edge N produces `rsp_valid` high in the cycle after edge N+1, i.e. 2 cycles from accept.
- Throughput: with `rsp_ready` held high, one op per 2 cycles.
- Response fields stay stable from `rsp_valid` rising until the handshake completes. Backpressure can last indefinitely.
- The ALU path is single-cycle combinational; operand registers to response registers is the only ALU timing path.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin arbitration as described above.
- `ALU_ARB_RR_EN` undefined: fixed priority, where port 0 always wins contention. The `last_grant` register and `RESET_LAST_GRANT` are unused and optimised away.

## Structure
- `cpu_types_pkg` gains `arb_state_t` (IDLE/EXEC/RESP) and `ALU_ARB_PORTS` = 2. It continues to supply `aluop_t` and `word_t`.
- One sub-module, `rr_pick2`: combinational 2-way picker. Inputs are valid[1:0] and last_grant; outputs are grant_valid and grant_idx. The fixed-priority variant is selected inside it by `ALU_ARB_RR_EN`.
- The top level instantiates `alu` through `alu_if`. The arbiter itself connects only to the ALU-side ports.

## Test plan
- Port 0 issues ADD 0x7FFFFFFF + 1 with `rsp_ready`=1. Expect `req_ready0` in the accept cycle, then `rsp_valid0` 2 cycles later with result 0x80000000, ovf=1, neg=1, zero=0.
- Both ports valid from reset: port 0 SUB 5-5, port 1 SLL 1<<31. With RR enabled, expect grants 0 then 1. Responses: 0 with zero=1, then 0x80000000 with neg=1.
- Port 1 holds `rsp_ready`=0 for 10 cycles while port 0 is valid. Expect `rsp_valid1` and the result to stay stable, `req_ready0` to stay 0, and port 0 to be granted in the handshake cycle.
- Both ports stream continuously with `rsp_ready`=11. Expect strict alternation, one response per 2 cycles, and never two `req_ready` or two `rsp_valid` bits set at once.
- Assert `RST` during EXEC. Expect all outputs at reset values immediately, no response delivered, and the next request to behave as the first after reset.
- Without `ALU_ARB_RR_EN`, both ports continuously valid: expect port 0 granted every time and port 1 never granted.
